// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the timer sequencer.
// Contents: state_e (sequencer FSM state, 4-bit encoding), PH_* phase codes and
// phase_of(), which maps a state onto the phase it reports.
package timer_seq_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StRun1 = 4'd1,
    StRel1 = 4'd2,
    StRun2 = 4'd3,
    StRel2 = 4'd4,
    StRun3 = 4'd5,
    StRel3 = 4'd6,
    StDone = 4'd7,
    StErr  = 4'd8
  } state_e;

  localparam logic [1:0] PH_IDLE = 2'd0;
  localparam logic [1:0] PH_KNIT = 2'd1;
  localparam logic [1:0] PH_DYE  = 2'd2;
  localparam logic [1:0] PH_PACK = 2'd3;

  // ERR has no phase of its own; the top level keeps the faulting phase instead.
  function automatic logic [1:0] phase_of(state_e s);
    case (s)
      StRun1, StRel1: phase_of = PH_KNIT;
      StRun2, StRel2: phase_of = PH_DYE;
      StRun3, StRel3: phase_of = PH_PACK;
      default:        phase_of = PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/timer_sequencer_if.sv
// Control and timer-handshake bundle of the timer sequencer.
// master: sequencer side (drives EN1..EN3 and status, samples requests and TI1..TI3).
// slave:  environment side (issues start/abort/clr_err, timers return TI1..TI3).
//   start, abort, clr_err : batch requests
//   TI1..TI3 / EN1..EN3   : timer timeouts / timer enables (knit, dye, pack)
//   busy, done, err       : status; done is a one-cycle pulse
//   phase                 : active phase (faulting phase while in error)
//   batch_cnt             : completed batches, wraps
interface timer_sequencer_if #(
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic             abort;
  logic             clr_err;
  logic             TI1;
  logic             TI2;
  logic             TI3;
  logic             EN1;
  logic             EN2;
  logic             EN3;
  logic             busy;
  logic             done;
  logic             err;
  logic [1:0]       phase;
  logic [CNT_W-1:0] batch_cnt;

  modport master (
    input  start, abort, clr_err, TI1, TI2, TI3,
    output EN1, EN2, EN3, busy, done, err, phase, batch_cnt
  );

  modport slave (
    output start, abort, clr_err, TI1, TI2, TI3,
    input  EN1, EN2, EN3, busy, done, err, phase, batch_cnt
  );
endinterface

// File: rtl/phase_watchdog.sv
// Per-state cycle watchdog for the timer sequencer.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clear      : zero the count (asserted on every sequencer state change)
//   count_en   : advance the count this cycle
//   expired    : count has reached WDOG_MAX
module phase_watchdog #(
  parameter int unsigned WDOG_MAX = 31
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int unsigned W = $clog2(WDOG_MAX + 1);

  logic [W-1:0] cnt_q;

  assign expired = (cnt_q == W'(WDOG_MAX));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (count_en && !expired) begin
      cnt_q <= cnt_q + W'(1);
    end
  end
endmodule

// File: rtl/timer_sequencer.sv
// Initiator side of the EN/TI timer handshake: runs knit, dye and pack in order,
// each as RUN (enable high until timeout) then REL (enable low until timeout
// returns low). A watchdog bounds every RUN/REL state and any timeout from a
// timer other than the active one is a protocol fault.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   bus        : timer_sequencer_if master modport (requests, TI in, EN/status out)
module timer_sequencer
  import timer_seq_pkg::*;
#(
  parameter int unsigned WDOG_MAX = 31,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_sequencer_if.master     bus
);

  state_e           state_q, state_d, adv_state;
  logic             in_run, in_rel, ti_own, ti_other;
  logic             wd_clear, wd_count, wd_expired;
  logic             en1_q, en2_q, en3_q, busy_q, done_q, err_q;
  logic [1:0]       phase_q;
  logic [CNT_W-1:0] cnt_q;

  // Which timeout belongs to the current phase, and where a clean exit leads.
  always_comb begin
    in_run    = 1'b0;
    in_rel    = 1'b0;
    ti_own    = 1'b0;
    ti_other  = 1'b0;
    adv_state = StIdle;
    case (state_q)
      StRun1: begin
        in_run = 1'b1; ti_own = bus.TI1; ti_other = bus.TI2 | bus.TI3; adv_state = StRel1;
      end
      StRel1: begin
        in_rel = 1'b1; ti_own = bus.TI1; ti_other = bus.TI2 | bus.TI3; adv_state = StRun2;
      end
      StRun2: begin
        in_run = 1'b1; ti_own = bus.TI2; ti_other = bus.TI1 | bus.TI3; adv_state = StRel2;
      end
      StRel2: begin
        in_rel = 1'b1; ti_own = bus.TI2; ti_other = bus.TI1 | bus.TI3; adv_state = StRun3;
      end
      StRun3: begin
        in_run = 1'b1; ti_own = bus.TI3; ti_other = bus.TI1 | bus.TI2; adv_state = StRel3;
      end
      StRel3: begin
        in_rel = 1'b1; ti_own = bus.TI3; ti_other = bus.TI1 | bus.TI2; adv_state = StDone;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (bus.start && !(bus.TI1 | bus.TI2 | bus.TI3)) state_d = StRun1;
      end
      StDone: state_d = StIdle;
      StErr: begin
        if (bus.clr_err) state_d = StIdle;
      end
      default: begin
        if (in_run || in_rel) begin
          if (bus.abort) begin
            state_d = StIdle;
          end else if (ti_other) begin
            state_d = StErr;
          end else if ((in_run && ti_own) || (in_rel && !ti_own)) begin
            state_d = adv_state;
          end else if (wd_expired) begin
            state_d = StErr;
          end
        end else begin
          state_d = StIdle; // unused encodings recover to idle
        end
      end
    endcase
  end

  assign wd_clear = (state_d != state_q);
  assign wd_count = in_run | in_rel;

  phase_watchdog #(
    .WDOG_MAX (WDOG_MAX)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .clear    (wd_clear),
    .count_en (wd_count),
    .expired  (wd_expired)
  );

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      en1_q   <= 1'b0;
      en2_q   <= 1'b0;
      en3_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      phase_q <= PH_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en1_q   <= (state_d == StRun1);
      en2_q   <= (state_d == StRun2);
      en3_q   <= (state_d == StRun3);
      busy_q  <= (state_d inside {StRun1, StRel1, StRun2, StRel2, StRun3, StRel3, StDone});
      done_q  <= (state_d == StDone);
      err_q   <= (state_d == StErr);
      if (state_d == StErr) begin
        // Latch the faulting phase on entry, then hold it.
        if (state_q != StErr) phase_q <= phase_of(state_q);
      end else begin
        phase_q <= phase_of(state_d);
      end
      if (state_d == StDone) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.EN1       = en1_q;
  assign bus.EN2       = en2_q;
  assign bus.EN3       = en3_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.phase     = phase_q;
  assign bus.batch_cnt = cnt_q;

endmodule

// File: tb/tb_timer_sequencer.sv
// Self-checking bench for timer_sequencer. Timers are modelled per cycle; the
// expected per-cycle outputs come from phase durations: RUNk lasts the timer
// latency (or WDOG+1 cycles then ERR), RELk one cycle, DONE one cycle.
module tb_timer_sequencer;
  localparam int unsigned WDOG = 31;
  localparam int unsigned CW   = 2;

  logic clk = 1'b0;
  logic reset;

  timer_sequencer_if #(.CNT_W(CW)) bus ();

  timer_sequencer #(
    .WDOG_MAX (WDOG),
    .CNT_W    (CW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          lat_t[3];
  bit          force_hi[3];
  int          tcnt[3];
  logic [2:0]  en_v;
  logic [CW-1:0] exp_cnt;
  bit          last_err;

  // Timer k: timeout rises once EN has been seen high lat_t[k] times, falls the
  // first time EN is seen low. force_hi injects a stuck/rogue timeout.
  always @(negedge clk) begin
    en_v = {bus.EN3, bus.EN2, bus.EN1};
    for (int k = 0; k < 3; k++) begin
      if (en_v[k]) tcnt[k] = tcnt[k] + 1;
      else         tcnt[k] = 0;
    end
    bus.TI1 = force_hi[0] | (en_v[0] && (tcnt[0] >= lat_t[0]));
    bus.TI2 = force_hi[1] | (en_v[1] && (tcnt[1] >= lat_t[1]));
    bus.TI3 = force_hi[2] | (en_v[2] && (tcnt[2] >= lat_t[2]));
  end

  task automatic check_now(input string tag, input logic [2:0] en, input logic [1:0] ph,
                           input logic bz, input logic dn, input logic er);
    logic [7+CW:0] obs, expv;
    obs  = {bus.EN3, bus.EN2, bus.EN1, bus.phase, bus.busy, bus.done, bus.err, bus.batch_cnt};
    expv = {en, ph, bz, dn, er, exp_cnt};
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s t=%0t obs(en,ph,busy,done,err,cnt)=%b exp=%b", tag, $time, obs, expv);
    end
  endtask

  task automatic step_check(input string tag, input logic [2:0] en, input logic [1:0] ph,
                            input logic bz, input logic dn, input logic er);
    @(posedge clk);
    #1;
    check_now(tag, en, ph, bz, dn, er);
  endtask

  // One batch with timer latencies l1..l3. cut>0: abort in REL(cut);
  // cut<0: asynchronous reset in RUN(-cut).
  task automatic run_batch(input string tag, input int l1, input int l2, input int l3,
                           input bit hold, input int cut);
    int lat[3];
    int n;
    lat[0] = l1; lat[1] = l2; lat[2] = l3;
    for (int k = 0; k < 3; k++) lat_t[k] = lat[k];
    last_err  = 1'b0;
    bus.start = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n = (lat[k] > int'(WDOG) + 1) ? int'(WDOG) + 1 : lat[k];
      for (int c = 0; c < n; c++) begin
        step_check(tag, 3'b001 << k, 2'(k + 1), 1'b1, 1'b0, 1'b0);
        if (!hold) bus.start = 1'b0;
        if (cut == -(k + 1) && c == 0) begin
          #1 reset = 1'b1;
          #1 exp_cnt = '0;
          check_now({tag, "_async"}, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
          bus.start = 1'b0;
          @(negedge clk);
          reset = 1'b0;
          return;
        end
      end
      if (lat[k] > int'(WDOG) + 1) begin
        step_check({tag, "_wdog_err"}, 3'b000, 2'(k + 1), 1'b0, 1'b0, 1'b1);
        bus.start = 1'b0;
        last_err  = 1'b1;
        return;
      end
      step_check({tag, "_rel"}, 3'b000, 2'(k + 1), 1'b1, 1'b0, 1'b0);
      if (cut == k + 1) begin
        bus.abort = 1'b1;
        step_check({tag, "_abort"}, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
        bus.abort = 1'b0;
        return;
      end
    end
    exp_cnt = exp_cnt + 1'b1;
    step_check({tag, "_done"}, 3'b000, 2'd0, 1'b1, 1'b1, 1'b0);
    step_check({tag, "_idle"}, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic clear_error(input string tag);
    bus.clr_err = 1'b1;
    step_check(tag, 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.clr_err = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.abort   = 1'b0;
    bus.clr_err = 1'b0;
    exp_cnt     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_now("reset_state", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    step_check("idle_after_reset", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    run_batch("nominal", 10, 18, 6, 1'b0, 0);
    step_check("nominal_idle", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Latency WDOG+1 is the last one that still completes.
    run_batch("wdog_edge", 32, 1, 32, 1'b0, 0);

    // Dead dye timer: ERR after 32 cycles of EN2; start/abort ignored in ERR.
    run_batch("dead_ti2", 5, 1000, 5, 1'b0, 0);
    bus.start = 1'b1;
    bus.abort = 1'b1;
    repeat (3) step_check("err_hold", 3'b000, 2'd2, 1'b0, 1'b0, 1'b1);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    clear_error("dead_clr");

    run_batch("overtime_knit", 33, 5, 5, 1'b0, 0);
    clear_error("overtime_clr");

    // Pack timeout during knit phase.
    lat_t[0]  = 20;
    bus.start = 1'b1;
    step_check("proto_run1", 3'b001, 2'd1, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    step_check("proto_run1", 3'b001, 2'd1, 1'b1, 1'b0, 1'b0);
    force_hi[2] = 1'b1;
    step_check("proto_err", 3'b000, 2'd1, 1'b0, 1'b0, 1'b1);
    clear_error("proto_clr");
    bus.start = 1'b1;
    repeat (3) step_check("start_blocked", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);
    bus.start   = 1'b0;
    force_hi[2] = 1'b0;
    step_check("unblocked_idle", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    run_batch("abort_rel2", 4, 6, 3, 1'b0, 2);
    step_check("abort_idle", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    repeat (4) begin
      run_batch("random", int'($urandom_range(36, 1)), int'($urandom_range(36, 1)),
                int'($urandom_range(36, 1)), 1'b0, 0);
      if (last_err) clear_error("random_clr");
    end

    run_batch("reset_run3", 3, 4, 8, 1'b0, -3);
    step_check("post_reset_idle", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    // Back-to-back with start held: counter 1,2,3,0,1.
    for (int b = 0; b < 5; b++) begin
      run_batch("b2b", int'($urandom_range(32, 1)), int'($urandom_range(32, 1)),
                int'($urandom_range(32, 1)), 1'b1, 0);
    end
    bus.start = 1'b0;
    step_check("b2b_final_idle", 3'b000, 2'd0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
Initiator side of the EN/TI timer handshake used by the sock-factory control path. On `start` it runs three phases in order: knit, dye, pack. For each phase it raises the phase enable, waits for that timer's timeout, and drops the enable. It then requires the timeout to return low before the next phase. A per-phase watchdog and a protocol check catch dead or misbehaving timers, and a completed-batch counter is maintained.

Parameters:
WDOG_MAX, 31, max cycle count allowed in any RUN/REL state before fault (>=1)
CNT_W, 8, width of completed-batch counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  level request to begin a batch (sampled in IDLE only)
abort  in  1  cancel current batch
clr_err  in  1  leave ERR state
TI1  in  1  knit timer timeout (same clock domain)
TI2  in  1  dye timer timeout
TI3  in  1  pack timer timeout
EN1  out  1  knit timer enable
EN2  out  1  dye timer enable
EN3  out  1  pack timer enable
busy  out  1  batch in progress
done  out  1  one-cycle pulse, batch finished
err  out  1  fault flag, held until cleared
phase  out  2  0 idle, 1/2/3 active phase; in ERR, the faulting phase
batch_cnt  out  CNT_W  completed batches, wraps

Behaviour:
- Reset (async, active-high): state IDLE, all outputs 0, watchdog 0, batch_cnt 0. Reset mid-batch drops EN immediately; no done pulse.
- All outputs are registered and decoded from state. ENk=1 only in RUNk; at most one EN is high at any time.
- States: IDLE, RUN1, REL1, RUN2, REL2, RUN3, REL3, DONE, ERR.
- IDLE:
  - start=1 and TI1..TI3 all 0 -> RUN1.
  - start=1 with any TI high -> stay in IDLE, no error.
- RUNk, checks in priority order:
  1. abort -> IDLE.
  2. Any TIj=1 with j!=k -> ERR.
  3. TIk=1 -> RELk.
  4. Watchdog==WDOG_MAX -> ERR.
  5. Otherwise watchdog++.
- RELk (EN all 0), checks in priority order:
  1. abort -> IDLE.
  2. Any TIj=1 with j!=k -> ERR.
  3. TIk=0 -> RUN(k+1); from REL3 -> DONE.
  4. Watchdog==WDOG_MAX -> ERR.
  5. Otherwise watchdog++.
- Watchdog: cleared to 0 on every state change. Width is $clog2(WDOG_MAX+1). So each RUN/REL state gets WDOG_MAX+1 sample cycles.
- DONE: lasts one cycle.
  - done=1 and batch_cnt+1 (2^CNT_W-1 wraps to 0).
  - Next state IDLE. If start is still high, RUN1 follows on the next cycle, so batches are back-to-back with one IDLE cycle between them.
- ERR:
  - err=1, EN all 0, busy=0, phase holds the faulting phase.
  - start and abort are ignored.
  - clr_err=1 -> IDLE (err, phase cleared). clr_err is ignored in every other state.
- abort in IDLE, DONE or ERR: ignored. Abort leaves batch_cnt unchanged and produces no done pulse.
- busy=1 in RUN1..REL3 and DONE. phase=k in RUNk/RELk, 0 in IDLE/DONE.

Decomposition:
- Package timer_seq_pkg: state enum (4-bit encoding), phase constants PH_IDLE/PH_KNIT/PH_DYE/PH_PACK.
- One sub-module phase_watchdog: clear input, count-enable input, `expired` output (count==WDOG_MAX), parameter WDOG_MAX.
- Top level holds the FSM, output registers and batch counter.

Test Plan:
- Nominal: WDOG_MAX=31, cycle-accurate timer models raise TIk 10/18/6 cycles after ENk rises and drop TIk one cycle after ENk falls; pulse start. Required: EN1, EN2, EN3 asserted in order, never overlapping; exactly one done pulse; batch_cnt 0->1; phase steps 1,2,3,0; err stays 0.
- Dead timer: TI2 tied 0. Required: ERR entered exactly 32 cycles after EN2 rises; err=1, phase=2, EN all 0. clr_err -> IDLE with err=0.
- Protocol violation: TI3 forced high during RUN1. Required: ERR next cycle with phase=1. Also, start asserted with TI3 high in IDLE -> stays IDLE, no error.
- Abort and reset: abort in REL2 -> IDLE next cycle, no done, batch_cnt unchanged. Async reset mid-RUN3 -> all outputs 0 before the next clock edge.
- Back-to-back and wrap: CNT_W=2, start held high across 5 batches. Required: batch_cnt sequence 1,2,3,0,1; one IDLE cycle between each DONE and the following RUN1.
